bus_xfer_sched: RTL and testbench



---
 rtl/bus_xfer_sched.sv | 120 ++++++++++++
 tb/tb_bus_xfer_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sched.sv
// Two-requester round-robin scheduler for a shared register bus: MOVE is one
// transfer, SWAP is three via scratch register NREG-1. Optional BXS_OPCHK_EN adds err.
module bus_xfer_sched #(
    parameter int NREG = 4,
    parameter int IW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req0_op,
    input  logic [IW-1:0]   req0_a,
    input  logic [IW-1:0]   req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic            req1_op,
    input  logic [IW-1:0]   req1_a,
    input  logic [IW-1:0]   req1_b,
    output logic            req1_ready,
    output logic [NREG-1:0] oe,
    output logic [NREG-1:0] ld,
    output logic            busy,
    output logic            grant_id,
    output logic            done
`ifdef BXS_OPCHK_EN
    ,
    output logic            err
`endif
);

    typedef enum logic [2:0] {IDLE, X1, X2, X3, FIN} state_t;

    localparam logic [IW-1:0] TREG = IW'(NREG - 1);

    state_t          state, nxt;
    logic            op_q, rr_ptr;
    logic [IW-1:0]   a_q, b_q;
    logic            pick1, accept, win_op;
    logic [IW-1:0]   win_a, win_b, src, dst;
    logic            xfer;

    // Requester 1 wins when it is the only one valid, or both are valid and it holds the pointer.
    assign pick1  = req1_valid && (!req0_valid || rr_ptr);
    assign accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign win_op = pick1 ? req1_op : req0_op;
    assign win_a  = pick1 ? req1_a  : req0_a;
    assign win_b  = pick1 ? req1_b  : req0_b;

    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

`ifdef BXS_OPCHK_EN
    logic bad_q, win_bad;
    assign win_bad = (win_a >= TREG) || (win_b >= TREG) || (win_a == win_b);
    assign err     = done && bad_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            rr_ptr   <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef BXS_OPCHK_EN
            bad_q    <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (accept) begin
                op_q     <= win_op;
                a_q      <= win_a;
                b_q      <= win_b;
                grant_id <= pick1;
                rr_ptr   <= ~pick1;
`ifdef BXS_OPCHK_EN
                bad_q    <= win_bad;
`endif
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) begin
`ifdef BXS_OPCHK_EN
                nxt = win_bad ? FIN : X1;
`else
                nxt = X1;
`endif
            end
            X1:      nxt = op_q ? X2 : FIN;
            X2:      nxt = X3;
            X3:      nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Moore decode of source/destination per transfer slot; indices >= NREG match no bit.
    always_comb begin
        xfer = 1'b1;
        src  = a_q;
        dst  = b_q;
        case (state)
            X1:      begin src = a_q;  dst = op_q ? TREG : b_q; end
            X2:      begin src = b_q;  dst = a_q;  end
            X3:      begin src = TREG; dst = b_q;  end
            default: xfer = 1'b0;
        endcase
        for (int i = 0; i < NREG; i++) begin
            oe[i] = xfer && (src == IW'(i));
            ld[i] = xfer && (dst == IW'(i));
        end
    end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed bench for bus_xfer_sched (NREG=4); optional-check steps follow BXS_OPCHK_EN.
module tb_bus_xfer_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_op, req0_ready;
    logic [1:0] req0_a, req0_b;
    logic       req1_valid, req1_op, req1_ready;
    logic [1:0] req1_a, req1_b;
    logic [3:0] oe, ld;
    logic       busy, grant_id, done;
`ifdef BXS_OPCHK_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;

    bus_xfer_sched #(.NREG(4), .IW(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .oe(oe), .ld(ld), .busy(busy), .grant_id(grant_id), .done(done)
`ifdef BXS_OPCHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer_chk(input string tag, input logic [3:0] eoe, input logic [3:0] eld,
                            input logic edone);
        chk({tag, ".oe"}, 32'(oe), 32'(eoe));
        chk({tag, ".ld"}, 32'(ld), 32'(eld));
        chk({tag, ".done"}, 32'(done), 32'(edone));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        tick(); tick();
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst.ready0", 32'(req0_ready), 0);
        chk("rst.ready1", 32'(req1_ready), 0);
        req0_valid = 0; req1_valid = 0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst.oe", 32'(oe), 0);
        chk("rst.ld", 32'(ld), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.grant", 32'(grant_id), 0);
        tick();

        // MOVE 0->2 from requester 0
        req0_valid = 1; req0_op = 0; req0_a = 0; req0_b = 2;
        #1;
        chk("mv.ready0", 32'(req0_ready), 1);
        chk("mv.ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 0;
        xfer_chk("mv.x1", 4'b0001, 4'b0100, 0);
        chk("mv.grant", 32'(grant_id), 0);
        tick();
        xfer_chk("mv.fin", 4'b0000, 4'b0000, 1);
        tick();
        chk("mv.idle.busy", 32'(busy), 0);
        chk("mv.idle.done", 32'(done), 0);

        // SWAP 1<->2 from requester 1
        req1_valid = 1; req1_op = 1; req1_a = 1; req1_b = 2;
        #1;
        chk("sw.ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        xfer_chk("sw.x1", 4'b0010, 4'b1000, 0);
        chk("sw.grant", 32'(grant_id), 1);
        tick();
        xfer_chk("sw.x2", 4'b0100, 4'b0010, 0);
        tick();
        xfer_chk("sw.x3", 4'b1000, 4'b0100, 0);
        tick();
        xfer_chk("sw.fin", 4'b0000, 4'b0000, 1);
        tick();
        chk("sw.idle.busy", 32'(busy), 0);

        // Both valid continuously: grants alternate 0,1,0,1
        req0_valid = 1; req0_op = 0; req0_a = 0; req0_b = 1;
        req1_valid = 1; req1_op = 0; req1_a = 2; req1_b = 0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("rr.ready0", 32'(req0_ready), 32'(g % 2 == 0));
            chk("rr.ready1", 32'(req1_ready), 32'(g % 2 == 1));
            tick();
            chk("rr.grant", 32'(grant_id), 32'(g % 2));
            xfer_chk("rr.x1", (g % 2 == 0) ? 4'b0001 : 4'b0100,
                     (g % 2 == 0) ? 4'b0010 : 4'b0001, 0);
            chk("rr.busy.ready", 32'({req0_ready, req1_ready}), 0);
            if (g == 3) begin req0_valid = 0; req1_valid = 0; end
            tick();
            chk("rr.fin.done", 32'(done), 1);
            chk("rr.fin.ready", 32'({req0_ready, req1_ready}), 0);
            tick();
        end
        chk("rr.end.busy", 32'(busy), 0);

        // Reset during X2 of a SWAP
        req0_valid = 1; req0_op = 1; req0_a = 0; req0_b = 1;
        #1;
        chk("rs.ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        tick();
        xfer_chk("rs.x2", 4'b0010, 4'b0001, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs.oe", 32'(oe), 0);
        chk("rs.ld", 32'(ld), 0);
        chk("rs.busy", 32'(busy), 0);
        chk("rs.done", 32'(done), 0);
        chk("rs.grant", 32'(grant_id), 0);
        tick();
        chk("rs.nodone", 32'(done), 0);
        req1_valid = 1; req1_op = 0; req1_a = 1; req1_b = 0;
        #1;
        chk("rs.ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        xfer_chk("rs.mv.x1", 4'b0010, 4'b0001, 0);
        chk("rs.mv.grant", 32'(grant_id), 1);
        tick();
        xfer_chk("rs.mv.fin", 4'b0000, 4'b0000, 1);
        tick();

`ifdef BXS_OPCHK_EN
        // Illegal SWAP a==b from requester 0 (pointer back at 0)
        req0_valid = 1; req0_op = 1; req0_a = 1; req0_b = 1;
        #1;
        chk("il.ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        xfer_chk("il.fin", 4'b0000, 4'b0000, 1);
        chk("il.err", 32'(err), 1);
        tick();
        chk("il.idle.err", 32'(err), 0);
        chk("il.idle.busy", 32'(busy), 0);
        // Illegal MOVE with scratch source from requester 1
        req1_valid = 1; req1_op = 0; req1_a = 3; req1_b = 0;
        #1;
        chk("il2.ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        xfer_chk("il2.fin", 4'b0000, 4'b0000, 1);
        chk("il2.err", 32'(err), 1);
        chk("il2.grant", 32'(grant_id), 1);
        tick();
        // Legal MOVE 2->0
        req0_valid = 1; req0_op = 0; req0_a = 2; req0_b = 0;
        #1;
        chk("lg.ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        xfer_chk("lg.x1", 4'b0100, 4'b0001, 0);
        chk("lg.x1.err", 32'(err), 0);
        tick();
        xfer_chk("lg.fin", 4'b0000, 4'b0000, 1);
        chk("lg.fin.err", 32'(err), 0);
        tick();
`else
        // a==b executes literally
        req0_valid = 1; req0_op = 0; req0_a = 2; req0_b = 2;
        #1;
        chk("eq.ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        xfer_chk("eq.x1", 4'b0100, 4'b0100, 0);
        tick();
        xfer_chk("eq.fin", 4'b0000, 4'b0000, 1);
        tick();
        chk("eq.idle.busy", 32'(busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
